// File: rtl/bp_lce_hybrid_resp_send_pkg.sv
// bp_lce_hybrid_resp_send_pkg: shared types for the LCE response transmitter.
// Rev 1.0
`default_nettype none

package bp_lce_hybrid_resp_send_pkg;

  localparam int PADDR_WIDTH         = 40;
  localparam int LCE_ID_WIDTH        = 4;
  localparam int CCE_ID_WIDTH        = 4;
  localparam int LCE_ASSOC           = 8;
  localparam int DWORD_WIDTH         = 64;
  localparam int DEFAULT_BLOCK_WIDTH = 512;
  localparam int CNT_WIDTH           = 16;

  typedef enum logic [3:0] {
    e_bedrock_resp_sync_ack = 4'd0,
    e_bedrock_resp_inv_ack  = 4'd1,
    e_bedrock_resp_coh_ack  = 4'd2,
    e_bedrock_resp_wb       = 4'd3,
    e_bedrock_resp_null_wb  = 4'd4
  } bp_bedrock_resp_type_e;

  typedef enum logic [1:0] {
    e_ack_sync    = 2'd0,
    e_ack_inv     = 2'd1,
    e_ack_coh     = 2'd2,
    e_ack_illegal = 2'd3
  } bp_lce_resp_ack_type_e;

  typedef struct packed {
    logic [LCE_ID_WIDTH-1:0] src_id;
    logic [CCE_ID_WIDTH-1:0] dst_id;
  } bp_bedrock_lce_resp_payload_s;

  typedef struct packed {
    bp_bedrock_lce_resp_payload_s payload;
    logic [2:0]                   size;
    logic [PADDR_WIDTH-1:0]       addr;
    logic [3:0]                   subop;
    bp_bedrock_resp_type_e        msg_type;
  } bp_bedrock_lce_resp_header_s;

  localparam int LCE_RESP_HEADER_WIDTH = $bits(bp_bedrock_lce_resp_header_s);

  function automatic bp_bedrock_resp_type_e ack_to_resp_type(input bp_lce_resp_ack_type_e t);
    case (t)
      e_ack_inv: return e_bedrock_resp_inv_ack;
      e_ack_coh: return e_bedrock_resp_coh_ack;
      default:   return e_bedrock_resp_sync_ack;
    endcase
  endfunction

  // BedRock size encoding is log2 of the byte count
  function automatic logic [2:0] block_msg_size(input int block_width);
    return 3'($clog2(block_width / 8));
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_lce_hybrid_resp_send_if.sv
// bp_lce_hybrid_resp_send_if: request and BedRock response signals of the transmitter.
// Rev 1.0
`default_nettype none

interface bp_lce_hybrid_resp_send_if
  import bp_lce_hybrid_resp_send_pkg::*;
#(
  parameter int LCE_DATA_WIDTH = DWORD_WIDTH,
  parameter int BLOCK_WIDTH    = DEFAULT_BLOCK_WIDTH
) ();

  logic [LCE_ID_WIDTH-1:0]          lce_id_i;

  logic                             ack_v_i;
  logic                             ack_ready_and_o;
  logic [1:0]                       ack_type_i;
  logic [PADDR_WIDTH-1:0]           ack_addr_i;
  logic [CCE_ID_WIDTH-1:0]          ack_dst_id_i;

  logic                             wb_v_i;
  logic                             wb_ready_and_o;
  logic                             wb_dirty_i;
  logic [PADDR_WIDTH-1:0]           wb_addr_i;
  logic [CCE_ID_WIDTH-1:0]          wb_dst_id_i;
  logic [BLOCK_WIDTH-1:0]           wb_data_i;

  bp_bedrock_lce_resp_header_s      lce_resp_header_o;
  logic                             lce_resp_header_v_o;
  logic                             lce_resp_header_ready_and_i;
  logic                             lce_resp_has_data_o;
  logic [LCE_DATA_WIDTH-1:0]        lce_resp_data_o;
  logic                             lce_resp_data_v_o;
  logic                             lce_resp_data_ready_and_i;
  logic                             lce_resp_last_o;

  logic [CNT_WIDTH-1:0]             wb_cnt_o;
  logic [CNT_WIDTH-1:0]             ack_cnt_o;

  modport master (
    input  lce_id_i,
    input  ack_v_i, ack_type_i, ack_addr_i, ack_dst_id_i,
    output ack_ready_and_o,
    input  wb_v_i, wb_dirty_i, wb_addr_i, wb_dst_id_i, wb_data_i,
    output wb_ready_and_o,
    output lce_resp_header_o, lce_resp_header_v_o, lce_resp_has_data_o,
    input  lce_resp_header_ready_and_i,
    output lce_resp_data_o, lce_resp_data_v_o, lce_resp_last_o,
    input  lce_resp_data_ready_and_i,
    output wb_cnt_o, ack_cnt_o
  );

  modport slave (
    output lce_id_i,
    output ack_v_i, ack_type_i, ack_addr_i, ack_dst_id_i,
    input  ack_ready_and_o,
    output wb_v_i, wb_dirty_i, wb_addr_i, wb_dst_id_i, wb_data_i,
    input  wb_ready_and_o,
    input  lce_resp_header_o, lce_resp_header_v_o, lce_resp_has_data_o,
    output lce_resp_header_ready_and_i,
    input  lce_resp_data_o, lce_resp_data_v_o, lce_resp_last_o,
    output lce_resp_data_ready_and_i,
    input  wb_cnt_o, ack_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/bp_lce_hybrid_resp_send_beat_serializer.sv
// bp_lce_resp_beat_serializer: parallel-load block register emitting one beat per advance, LSW first.
// Rev 1.0
`default_nettype none

module bp_lce_resp_beat_serializer #(
  parameter int BLOCK_WIDTH = 512,
  parameter int DATA_WIDTH  = 64
) (
  input  wire logic                   clk,
  input  wire logic                   reset_n,
  input  wire logic                   load,
  input  wire logic [BLOCK_WIDTH-1:0] blk_in,
  input  wire logic                   advance,
  output logic      [DATA_WIDTH-1:0]  beat,
  output logic                        last,
  output logic                        done
);

  localparam int BEATS     = BLOCK_WIDTH / DATA_WIDTH;
  localparam int BEAT_CNTW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_CNTW-1:0] LAST_BEAT = BEAT_CNTW'(BEATS - 1);

  logic [BLOCK_WIDTH-1:0] shift_reg;
  logic [BEAT_CNTW-1:0]   beat_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_reg <= '0;
      beat_cnt  <= '0;
    end else if (load) begin
      shift_reg <= blk_in;
      beat_cnt  <= '0;
    end else if (advance) begin
      shift_reg <= shift_reg >> DATA_WIDTH;
      beat_cnt  <= last ? '0 : beat_cnt + 1'b1;
    end
  end

  assign beat = shift_reg[DATA_WIDTH-1:0];
  assign last = (beat_cnt == LAST_BEAT);
  assign done = advance & last;

endmodule

`default_nettype wire

// File: rtl/bp_lce_hybrid_resp_send.sv
// bp_lce_hybrid_resp_send: arbitrates acks and writebacks into BedRock burst responses (header, then data).
// Rev 1.0 -- optional sent-message counters enabled by BP_LCE_RESP_SEND_CNT_EN.
`default_nettype none

module bp_lce_hybrid_resp_send
  import bp_lce_hybrid_resp_send_pkg::*;
#(
  parameter int LCE_DATA_WIDTH = DWORD_WIDTH,
  parameter int BLOCK_WIDTH    = DEFAULT_BLOCK_WIDTH
) (
  input wire logic                 clk_i,
  input wire logic                 reset_n_i,
  bp_lce_hybrid_resp_send_if.master bus
);

  localparam logic [2:0] BLOCK_SIZE = block_msg_size(BLOCK_WIDTH);

  generate
    if ((BLOCK_WIDTH % LCE_DATA_WIDTH) != 0 || BLOCK_WIDTH < LCE_DATA_WIDTH) begin : g_bad_beat_ratio
      $error("BLOCK_WIDTH must be a positive integer multiple of LCE_DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e                      state, state_next;
  bp_bedrock_lce_resp_header_s hdr;
  logic                        dirty;

  logic wb_ready, ack_ready, hdr_v, data_v;
  logic wb_fire, ack_fire, ack_legal, hdr_fire, data_fire;
  logic ser_last, ser_done;
  logic [LCE_DATA_WIDTH-1:0] ser_beat;

  assign ack_legal = (bp_lce_resp_ack_type_e'(bus.ack_type_i) != e_ack_illegal);
  assign wb_fire   = bus.wb_v_i & wb_ready;
  assign ack_fire  = bus.ack_v_i & ack_ready;
  assign hdr_fire  = hdr_v & bus.lce_resp_header_ready_and_i;
  assign data_fire = data_v & bus.lce_resp_data_ready_and_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state <= S_IDLE;
    else            state <= state_next;
  end

  // Writebacks win over acks; an illegal ack is consumed without leaving IDLE
  always_comb begin
    state_next = state;
    wb_ready   = 1'b0;
    ack_ready  = 1'b0;
    hdr_v      = 1'b0;
    data_v     = 1'b0;
    case (state)
      S_IDLE: begin
        wb_ready  = 1'b1;
        ack_ready = ~bus.wb_v_i;
        if (bus.wb_v_i)                    state_next = S_HDR;
        else if (bus.ack_v_i && ack_legal) state_next = S_HDR;
      end
      S_HDR: begin
        hdr_v = 1'b1;
        if (bus.lce_resp_header_ready_and_i) state_next = dirty ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        data_v = 1'b1;
        if (ser_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hdr   <= '0;
      dirty <= 1'b0;
    end else if (wb_fire) begin
      hdr.payload.src_id <= bus.lce_id_i;
      hdr.payload.dst_id <= bus.wb_dst_id_i;
      hdr.size           <= BLOCK_SIZE;
      hdr.addr           <= bus.wb_addr_i;
      hdr.subop          <= '0;
      hdr.msg_type       <= bus.wb_dirty_i ? e_bedrock_resp_wb : e_bedrock_resp_null_wb;
      dirty              <= bus.wb_dirty_i;
    end else if (ack_fire && ack_legal) begin
      hdr.payload.src_id <= bus.lce_id_i;
      hdr.payload.dst_id <= bus.ack_dst_id_i;
      hdr.size           <= BLOCK_SIZE;
      hdr.addr           <= bus.ack_addr_i;
      hdr.subop          <= '0;
      hdr.msg_type       <= ack_to_resp_type(bp_lce_resp_ack_type_e'(bus.ack_type_i));
      dirty              <= 1'b0;
    end
  end

  bp_lce_resp_beat_serializer #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .DATA_WIDTH  (LCE_DATA_WIDTH)
  ) u_serializer (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .load    (wb_fire & bus.wb_dirty_i),
    .blk_in  (bus.wb_data_i),
    .advance (data_fire),
    .beat    (ser_beat),
    .last    (ser_last),
    .done    (ser_done)
  );

  assign bus.wb_ready_and_o      = wb_ready;
  assign bus.ack_ready_and_o     = ack_ready;
  assign bus.lce_resp_header_o   = hdr;
  assign bus.lce_resp_header_v_o = hdr_v;
  assign bus.lce_resp_has_data_o = dirty;
  assign bus.lce_resp_data_o     = ser_beat;
  assign bus.lce_resp_data_v_o   = data_v;
  assign bus.lce_resp_last_o     = data_v & ser_last;

`ifdef BP_LCE_RESP_SEND_CNT_EN
  logic [CNT_WIDTH-1:0] wb_cnt, ack_cnt;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wb_cnt  <= '0;
      ack_cnt <= '0;
    end else if (hdr_fire) begin
      if (hdr.msg_type == e_bedrock_resp_wb || hdr.msg_type == e_bedrock_resp_null_wb)
        wb_cnt <= sat_inc(wb_cnt);
      else
        ack_cnt <= sat_inc(ack_cnt);
    end
  end

  assign bus.wb_cnt_o  = wb_cnt;
  assign bus.ack_cnt_o = ack_cnt;
`else
  assign bus.wb_cnt_o  = '0;
  assign bus.ack_cnt_o = '0;
`endif

  a_no_illegal_ack : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(ack_fire && !ack_legal));

endmodule

`default_nettype wire

// File: tb/tb_bp_lce_hybrid_resp_send.sv
// tb_bp_lce_hybrid_resp_send: table vectors, corner sequences and random traffic against a message-level model.
// Rev 1.0
`default_nettype none

module tb_bp_lce_hybrid_resp_send;
  import bp_lce_hybrid_resp_send_pkg::*;

  localparam int DW = 64;
  localparam int BW = 512;
  localparam int N  = BW / DW;
  localparam logic [LCE_ID_WIDTH-1:0] LCE_ID = 4'h5;

  typedef struct {
    bp_bedrock_lce_resp_header_s hdr;
    logic                        has_data;
    logic [BW-1:0]               blk;
  } msg_t;

  typedef struct {
    bit                     is_wb;
    bit                     dirty;
    logic [1:0]             atype;
    logic [PADDR_WIDTH-1:0] addr;
    logic [3:0]             dst;
    bp_bedrock_resp_type_e  exp_type;
    bit                     exp_has_data;
    int                     exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_lce_hybrid_resp_send_if #(.LCE_DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) bus ();

  bp_lce_hybrid_resp_send #(.LCE_DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus.master)
  );

  int   n_vec = 0;
  int   n_err = 0;
  msg_t exp_q[$];
  int   cnt_wb = 0;
  int   cnt_ack = 0;
  bit   stall_en = 0;
  bit   freeze = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic msg_t mk(input bp_bedrock_resp_type_e t, input logic [PADDR_WIDTH-1:0] addr,
                              input logic [3:0] dst, input bit has_data, input logic [BW-1:0] blk);
    msg_t m;
    m.hdr.msg_type       = t;
    m.hdr.subop          = 4'd0;
    m.hdr.addr           = addr;
    m.hdr.size           = 3'($clog2(BW / 8));
    m.hdr.payload.src_id = LCE_ID;
    m.hdr.payload.dst_id = dst;
    m.has_data           = has_data;
    m.blk                = blk;
    return m;
  endfunction

  // Reference: what the LCE should send for a given request
  function automatic msg_t model_msg(input bit is_wb, input bit dirty, input logic [1:0] atype,
                                     input logic [PADDR_WIDTH-1:0] addr, input logic [3:0] dst,
                                     input logic [BW-1:0] blk);
    bp_bedrock_resp_type_e t;
    if (is_wb)              t = dirty ? e_bedrock_resp_wb : e_bedrock_resp_null_wb;
    else if (atype == 2'd1) t = e_bedrock_resp_inv_ack;
    else if (atype == 2'd2) t = e_bedrock_resp_coh_ack;
    else                    t = e_bedrock_resp_sync_ack;
    return mk(t, addr, dst, is_wb && dirty, blk);
  endfunction

  // Monitor: every header/beat handshake is scored against the expected-message queue
  bit                          burst_active = 0;
  int                          beat_idx = 0;
  logic [BW-1:0]               cur_blk;
  bit                          hs_prev = 0, ds_prev = 0;
  bp_bedrock_lce_resp_header_s hdr_prev;
  logic [DW-1:0]               data_prev;
  logic                        last_prev;
  msg_t                        mon_m;

  always @(negedge clk) begin
    if (!reset_n) begin
      burst_active = 0;
      hs_prev      = 0;
      ds_prev      = 0;
    end else begin
      if (hs_prev) begin
        chk("hdr_stall_valid", bus.lce_resp_header_v_o, 1'b1);
        chk("hdr_stall_stable", bus.lce_resp_header_o, hdr_prev);
      end
      if (ds_prev) begin
        chk("data_stall_valid", bus.lce_resp_data_v_o, 1'b1);
        chk("data_stall_stable", {bus.lce_resp_data_o, bus.lce_resp_last_o}, {data_prev, last_prev});
      end
      if (bus.lce_resp_header_v_o) begin
        chk("hdr_during_burst", burst_active, 1'b0);
        hs_prev  = !bus.lce_resp_header_ready_and_i;
        hdr_prev = bus.lce_resp_header_o;
        if (bus.lce_resp_header_ready_and_i) begin
          chk("hdr_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            mon_m = exp_q.pop_front();
            chk("hdr_fields", bus.lce_resp_header_o, mon_m.hdr);
            chk("has_data", bus.lce_resp_has_data_o, mon_m.has_data);
            if (mon_m.has_data) begin
              burst_active = 1;
              beat_idx     = 0;
              cur_blk      = mon_m.blk;
            end
          end
        end
      end else hs_prev = 0;
      if (bus.lce_resp_data_v_o) begin
        chk("data_after_hdr", burst_active, 1'b1);
        ds_prev   = !bus.lce_resp_data_ready_and_i;
        data_prev = bus.lce_resp_data_o;
        last_prev = bus.lce_resp_last_o;
        if (burst_active) begin
          chk("beat_data", bus.lce_resp_data_o, cur_blk[beat_idx*DW +: DW]);
          chk("beat_last", bus.lce_resp_last_o, beat_idx == N - 1);
          if (bus.lce_resp_data_ready_and_i) begin
            beat_idx++;
            if (beat_idx == N) burst_active = 0;
          end
        end
      end else ds_prev = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.lce_resp_header_ready_and_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.lce_resp_data_ready_and_i   = freeze ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  task automatic send(input bit is_wb, input bit dirty, input logic [1:0] atype,
                      input logic [PADDR_WIDTH-1:0] addr, input logic [3:0] dst,
                      input logic [BW-1:0] blk, input msg_t m, input int exp_lat);
    bit accepted = 0;
    int lat = 0;
    @(posedge clk); #1;
    if (is_wb) begin
      bus.wb_v_i = 1; bus.wb_dirty_i = dirty; bus.wb_addr_i = addr;
      bus.wb_dst_id_i = dst; bus.wb_data_i = blk;
    end else begin
      bus.ack_v_i = 1; bus.ack_type_i = atype; bus.ack_addr_i = addr; bus.ack_dst_id_i = dst;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (is_wb ? bus.wb_ready_and_o : bus.ack_ready_and_o) begin
        accepted = 1;
        break;
      end
    end
    chk("accept_timeout", accepted, 1'b1);
    if (accepted) begin
      exp_q.push_back(m);
      if (is_wb) cnt_wb++; else cnt_ack++;
    end
    @(posedge clk); #1;
    bus.wb_v_i = 0; bus.ack_v_i = 0;
    if (accepted && exp_lat > 0) begin
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        lat++;
        if (lat == 1) chk("hdr_next_cycle", bus.lce_resp_header_v_o, 1'b1);
        if (bus.wb_ready_and_o) break;
      end
      chk("idle_latency", lat, exp_lat);
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !burst_active) begin
        ok = 1;
        break;
      end
    end
    chk("drain_timeout", ok, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 0;
    @(posedge clk); #1 reset_n = 1;
    exp_q.delete();
    cnt_wb = 0;
    cnt_ack = 0;
  endtask

  task automatic check_counters(input string name);
`ifdef BP_LCE_RESP_SEND_CNT_EN
    chk({name, "_wb_cnt"},  bus.wb_cnt_o,  cnt_wb);
    chk({name, "_ack_cnt"}, bus.ack_cnt_o, cnt_ack);
`else
    chk({name, "_wb_cnt"},  bus.wb_cnt_o,  0);
    chk({name, "_ack_cnt"}, bus.ack_cnt_o, 0);
`endif
  endtask

  function automatic logic [BW-1:0] ramp_blk(input logic [DW-1:0] base);
    logic [BW-1:0] b;
    for (int i = 0; i < N; i++) b[i*DW +: DW] = base + DW'(i);
    return b;
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  vec_t tbl[5];

  initial begin
    logic [BW-1:0]          blk;
    logic [PADDR_WIDTH-1:0] addr;
    bit                     is_wb, dirty, ok;
    logic [1:0]             atype;
    logic [3:0]             dst;
    int                     lat;

    bus.lce_id_i = LCE_ID;
    bus.ack_v_i = 0; bus.ack_type_i = 0; bus.ack_addr_i = '0; bus.ack_dst_id_i = '0;
    bus.wb_v_i = 0; bus.wb_dirty_i = 0; bus.wb_addr_i = '0; bus.wb_dst_id_i = '0; bus.wb_data_i = '0;
    bus.lce_resp_header_ready_and_i = 1; bus.lce_resp_data_ready_and_i = 1;

    tbl[0] = '{0, 0, 2'd1, 40'h80_0000_0040, 4'd2, e_bedrock_resp_inv_ack,  0, 2};
    tbl[1] = '{0, 0, 2'd0, 40'h12_3456_7880, 4'd1, e_bedrock_resp_sync_ack, 0, 2};
    tbl[2] = '{0, 0, 2'd2, 40'hFF_FFFF_FFC0, 4'd3, e_bedrock_resp_coh_ack,  0, 2};
    tbl[3] = '{1, 1, 2'd0, 40'h00_0000_1000, 4'd0, e_bedrock_resp_wb,       1, N + 2};
    tbl[4] = '{1, 0, 2'd0, 40'h00_0000_2040, 4'd7, e_bedrock_resp_null_wb,  0, 2};

    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    chk("rst_hdr_v",   bus.lce_resp_header_v_o, 1'b0);
    chk("rst_data_v",  bus.lce_resp_data_v_o, 1'b0);
    chk("rst_last",    bus.lce_resp_last_o, 1'b0);
    chk("rst_wb_rdy",  bus.wb_ready_and_o, 1'b1);
    chk("rst_ack_rdy", bus.ack_ready_and_o, 1'b1);
    check_counters("rst");

    // Directed table: beats of the dirty entry are 0..N-1
    blk = ramp_blk(64'h0);
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].is_wb, tbl[i].dirty, tbl[i].atype, tbl[i].addr, tbl[i].dst, blk,
           mk(tbl[i].exp_type, tbl[i].addr, tbl[i].dst, tbl[i].exp_has_data, blk), tbl[i].exp_lat);
      drain();
    end

    // wb and ack together: wb first, ack only after the wb burst completes
    blk = ramp_blk(64'h100);
    @(posedge clk); #1;
    bus.wb_v_i = 1; bus.wb_dirty_i = 1; bus.wb_addr_i = 40'h4000; bus.wb_dst_id_i = 4'd1; bus.wb_data_i = blk;
    bus.ack_v_i = 1; bus.ack_type_i = 2'd2; bus.ack_addr_i = 40'h4040; bus.ack_dst_id_i = 4'd2;
    @(negedge clk);
    chk("prio_wb_ready", bus.wb_ready_and_o, 1'b1);
    chk("prio_ack_ready", bus.ack_ready_and_o, 1'b0);
    exp_q.push_back(mk(e_bedrock_resp_wb, 40'h4000, 4'd1, 1, blk)); cnt_wb++;
    @(posedge clk); #1 bus.wb_v_i = 0;
    lat = 0; ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); lat++;
      if (bus.ack_ready_and_o) begin ok = 1; break; end
    end
    chk("prio_ack_wait", lat, N + 2);
    if (ok) begin exp_q.push_back(mk(e_bedrock_resp_coh_ack, 40'h4040, 4'd2, 0, '0)); cnt_ack++; end
    @(posedge clk); #1 bus.ack_v_i = 0;
    drain();

    // Stalled header and data
    stall_en = 1;
    blk = ramp_blk(64'hA0);
    send(1, 1, 0, 40'h8000, 4'd3, blk, model_msg(1, 1, 0, 40'h8000, 4'd3, blk), 0);
    drain();
    stall_en = 0;

    // Reset in the middle of a burst, then a fresh burst from beat 0
    blk = ramp_blk(64'hB0);
    send(1, 1, 0, 40'hC000, 4'd4, blk, model_msg(1, 1, 0, 40'hC000, 4'd4, blk), 0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (burst_active && beat_idx == 4) begin ok = 1; break; end
    end
    chk("mid_burst_reached", ok, 1'b1);
    freeze = 1; bus.lce_resp_data_ready_and_i = 0;
    @(posedge clk); #1 reset_n = 0;
    @(posedge clk); #1;
    chk("rst_mid_hdr_v",  bus.lce_resp_header_v_o, 1'b0);
    chk("rst_mid_data_v", bus.lce_resp_data_v_o, 1'b0);
    exp_q.delete(); cnt_wb = 0; cnt_ack = 0;
    reset_n = 1; freeze = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {bus.lce_resp_header_v_o, bus.lce_resp_data_v_o}, 2'b00);
    end
    check_counters("post_rst");
    blk = ramp_blk(64'hC0);
    send(1, 1, 0, 40'hC000, 4'd4, blk, model_msg(1, 1, 0, 40'hC000, 4'd4, blk), N + 2);
    drain();

    // Counters: 3 wb + 1 null_wb + 2 acks
    do_reset();
    for (int i = 0; i < 3; i++) begin
      blk = rand_blk();
      send(1, 1, 0, 40'(i * 64), 4'd1, blk, model_msg(1, 1, 0, 40'(i * 64), 4'd1, blk), 0);
    end
    send(1, 0, 0, 40'h200, 4'd2, '0, model_msg(1, 0, 0, 40'h200, 4'd2, '0), 0);
    send(0, 0, 2'd1, 40'h240, 4'd3, '0, model_msg(0, 0, 2'd1, 40'h240, 4'd3, '0), 0);
    send(0, 0, 2'd2, 40'h280, 4'd3, '0, model_msg(0, 0, 2'd2, 40'h280, 4'd3, '0), 0);
    drain();
    @(negedge clk);
    check_counters("cnt_mix");

    // Random traffic with random back-pressure
    stall_en = 1;
    for (int i = 0; i < 60; i++) begin
      is_wb = 1'($urandom_range(0, 1));
      dirty = 1'($urandom_range(0, 1));
      atype = 2'($urandom_range(0, 2));
      dst   = 4'($urandom_range(0, 15));
      addr  = {8'($urandom_range(0, 255)), $urandom()};
      addr[5:0] = 6'd0;
      blk   = rand_blk();
      send(is_wb, dirty, atype, addr, dst, blk, model_msg(is_wb, dirty, atype, addr, dst, blk), 0);
    end
    drain();
    stall_en = 0;
    @(negedge clk);
    check_counters("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
